// File: rtl/riscv_defines.sv
// Shared RISC-V fetch-path definitions: word width, realigner state encoding
// and the instruction-length helper.
package riscv_defines;

    localparam int RISCV_WORD_WIDTH = 32;
    localparam int RISCV_HALF_WIDTH = 16;

    // Low two bits of a halfword equal to this mark the start of a 32-bit instruction.
    localparam logic [1:0] RVC_LEN_32 = 2'b11;

    typedef enum logic [1:0] {
        RA_EMPTY = 2'd0,
        RA_HALF  = 2'd1,
        RA_SKIP  = 2'd2
    } realign_state_e;

    function automatic logic is_rvc(input logic [1:0] low_bits);
        return low_bits != RVC_LEN_32;
    endfunction

endpackage

// File: rtl/instr_realigner.sv
// Turns word-aligned fetch words into one RVC or 32-bit instruction per
// handshake, stitching instructions that straddle a word boundary.
module instr_realigner
    import riscv_defines::*;
#(
    parameter logic [RISCV_WORD_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        fetch_valid_i,
    output logic                        fetch_ready_o,
    input  logic [RISCV_WORD_WIDTH-1:0] fetch_data_i,
    output logic                        instr_valid_o,
    input  logic                        instr_ready_i,
    output logic [RISCV_WORD_WIDTH-1:0] instr_o,
    output logic [RISCV_WORD_WIDTH-1:0] instr_addr_o,
    input  logic                        flush_i,
    input  logic [RISCV_WORD_WIDTH-1:0] flush_pc_i
);

    // Valid/ready: an instruction transfers when instr_valid_o & instr_ready_i,
    // a fetch word transfers when fetch_valid_i & fetch_ready_o; neither valid
    // depends on the corresponding ready, and fetch_ready_o only rises when the
    // whole presented word is consumed in that same cycle.

    localparam realign_state_e RESET_STATE = RESET_PC[1] ? RA_SKIP : RA_EMPTY;

    realign_state_e              state_q, state_d;
    logic [RISCV_HALF_WIDTH-1:0] stash_q, stash_d;
    logic [RISCV_WORD_WIDTH-1:0] pc_q, pc_d;

    logic [RISCV_HALF_WIDTH-1:0] fetch_lo;
    logic [RISCV_HALF_WIDTH-1:0] fetch_hi;
    logic                        instr_is_32;
    logic                        instr_hs;

    assign fetch_lo     = fetch_data_i[RISCV_HALF_WIDTH-1:0];
    assign fetch_hi     = fetch_data_i[RISCV_WORD_WIDTH-1:RISCV_HALF_WIDTH];
    assign instr_hs     = instr_valid_o & instr_ready_i;
    assign instr_addr_o = pc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RESET_STATE;
            stash_q <= '0;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            stash_q <= stash_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        stash_d = stash_q;
        pc_d    = pc_q;
        if (flush_i) begin
            state_d = flush_pc_i[1] ? RA_SKIP : RA_EMPTY;
            stash_d = '0;
            pc_d    = flush_pc_i;
        end else begin
            case (state_q)
                RA_EMPTY: begin
                    if (instr_hs) begin
                        pc_d = pc_q + (instr_is_32 ? 32'd4 : 32'd2);
                        if (!instr_is_32) begin
                            stash_d = fetch_hi;
                            state_d = RA_HALF;
                        end
                    end
                end
                RA_HALF: begin
                    if (instr_hs) begin
                        pc_d = pc_q + (instr_is_32 ? 32'd4 : 32'd2);
                        // A straddling instruction leaves the next word's upper half behind.
                        if (instr_is_32) begin
                            stash_d = fetch_hi;
                        end else begin
                            state_d = RA_EMPTY;
                        end
                    end
                end
                RA_SKIP: begin
                    if (fetch_valid_i) begin
                        stash_d = fetch_hi;
                        state_d = RA_HALF;
                    end
                end
                default: begin
                    state_d = RA_EMPTY;
                end
            endcase
        end
    end

    // Reset is folded in here so outputs go quiet the moment rst_n drops.
    always_comb begin
        instr_valid_o = 1'b0;
        fetch_ready_o = 1'b0;
        instr_o       = '0;
        instr_is_32   = 1'b0;
        if (rst_n && !flush_i) begin
            case (state_q)
                RA_EMPTY: begin
                    if (fetch_valid_i) begin
                        instr_valid_o = 1'b1;
                        fetch_ready_o = instr_ready_i;
                        if (is_rvc(fetch_lo[1:0])) begin
                            instr_o = {16'h0000, fetch_lo};
                        end else begin
                            instr_o     = fetch_data_i;
                            instr_is_32 = 1'b1;
                        end
                    end
                end
                RA_HALF: begin
                    if (is_rvc(stash_q[1:0])) begin
                        instr_valid_o = 1'b1;
                        instr_o       = {16'h0000, stash_q};
                    end else begin
                        instr_valid_o = fetch_valid_i;
                        fetch_ready_o = fetch_valid_i & instr_ready_i;
                        instr_o       = {fetch_lo, stash_q};
                        instr_is_32   = 1'b1;
                    end
                end
                RA_SKIP: begin
                    fetch_ready_o = 1'b1;
                end
                default: begin
                    fetch_ready_o = 1'b0;
                end
            endcase
        end
    end

endmodule
